// File: rtl/sar_scan_ctrl_if.sv
// Signal bundle between the scan sequencer, the system control block and the SAR logic / analog mux.
interface sar_scan_ctrl_if #(
   parameter int NCH = 4
);
   logic           start;
   logic           cont;
   logic [NCH-1:0] ch_mask;
   logic [2:0]     mux_sel;
   logic           sample;
   logic           sar_rest;
   logic           sar_ena;
   logic           sar_done;
   logic [5:0]     sar_dout;
   logic [5:0]     res_data;
   logic [2:0]     res_ch;
   logic           res_valid;
   logic           res_ready;
   logic           busy;
   logic           err;

   modport slave (
      input  start, cont, ch_mask, sar_done, sar_dout, res_ready,
      output mux_sel, sample, sar_rest, sar_ena, res_data, res_ch, res_valid, busy, err
   );

   modport master (
      output start, cont, ch_mask, sar_done, sar_dout, res_ready,
      input  mux_sel, sample, sar_rest, sar_ena, res_data, res_ch, res_valid, busy, err
   );
endinterface

// File: rtl/sar_scan_ctrl.sv
// Scan sequencer: walks the enabled channels through sample and SAR conversion, one result per channel.
//   state  | meaning
//   IDLE   | SAR held in reset, waiting for a start with a non-empty mask
//   SAMPLE | mux on current channel, track switch closed for SAMPLE_CYC cycles
//   CONV   | SAR enabled, waiting for sar_done or the timeout
//   OUT    | result held on the output port until the consumer takes it
module sar_scan_ctrl #(
   parameter int NCH        = 4,
   parameter int SAMPLE_CYC = 2,
   parameter int TMO        = 15
) (
   input  logic              clk,
   input  logic              rest,
   sar_scan_ctrl_if.slave    bus
);
   localparam int CW = 8;

   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, OUT} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [NCH-1:0] mreg;
   logic [2:0]     ch;
   logic           sample;
   logic           sar_rest;
   logic           sar_ena;
   logic [5:0]     res_data;
   logic [2:0]     res_ch;
   logic           res_valid;
   logic           busy;
   logic           err;

   logic [2:0]     lo_in;
   logic [2:0]     lo_m;
   logic [2:0]     nx;
   logic           nx_found;

   // Priority encoders: descending loops leave the lowest qualifying index.
   always_comb begin
      lo_in    = '0;
      lo_m     = '0;
      nx       = '0;
      nx_found = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (bus.ch_mask[i]) lo_in = 3'(i);
         if (mreg[i]) lo_m = 3'(i);
         if (mreg[i] && (i > int'(ch))) begin
            nx       = 3'(i);
            nx_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         state     <= IDLE;
         cnt       <= '0;
         mreg      <= '0;
         ch        <= '0;
         sample    <= 1'b0;
         sar_rest  <= 1'b1;
         sar_ena   <= 1'b0;
         res_data  <= '0;
         res_ch    <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && (bus.ch_mask != '0)) begin
                  mreg   <= bus.ch_mask;
                  ch     <= lo_in;
                  err    <= 1'b0;
                  cnt    <= CW'(SAMPLE_CYC - 1);
                  sample <= 1'b1;
                  busy   <= 1'b1;
                  state  <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (cnt == '0) begin
                  // Timeout reuses the down-counter: TMO cycles in CONV before giving up.
                  cnt      <= CW'(TMO - 1);
                  sample   <= 1'b0;
                  sar_rest <= 1'b0;
                  sar_ena  <= 1'b1;
                  state    <= CONV;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CONV: begin
               if (bus.sar_done) begin
                  res_data  <= bus.sar_dout;
                  res_ch    <= ch;
                  res_valid <= 1'b1;
                  sar_rest  <= 1'b1;
                  sar_ena   <= 1'b0;
                  state     <= OUT;
               end else if (cnt == '0) begin
                  err      <= 1'b1;
                  sar_rest <= 1'b1;
                  sar_ena  <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            OUT: begin
               if (bus.res_ready) begin
                  res_valid <= 1'b0;
                  if (nx_found || bus.cont) begin
                     ch     <= nx_found ? nx : lo_m;
                     cnt    <= CW'(SAMPLE_CYC - 1);
                     sample <= 1'b1;
                     state  <= SAMPLE;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mux_sel   = ch;
   assign bus.sample    = sample;
   assign bus.sar_rest  = sar_rest;
   assign bus.sar_ena   = sar_ena;
   assign bus.res_data  = res_data;
   assign bus.res_ch    = res_ch;
   assign bus.res_valid = res_valid;
   assign bus.busy      = busy;
   assign bus.err       = err;
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Bench for sar_scan_ctrl: SAR behavioural model, result scoreboard, vector table plus corner sequences.
module tb_sar_scan_ctrl;
   localparam int NCH        = 4;
   localparam int SAMPLE_CYC = 2;
   localparam int TMO        = 15;
   localparam int SAR_LAT    = 8;

   typedef struct {
      logic [2:0] ch;
      logic [5:0] data;
   } res_t;

   typedef struct {
      logic [3:0] mask;
      int         nres;
   } vec_t;

   logic clk = 1'b0;
   logic rest;
   sar_scan_ctrl_if #(.NCH(NCH)) bus ();

   sar_scan_ctrl #(.NCH(NCH), .SAMPLE_CYC(SAMPLE_CYC), .TMO(TMO)) dut (
      .clk  (clk),
      .rest (rest),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   nvec = 0;
   int   nerr = 0;
   res_t q[$];
   int   npop = 0;
   int   sample_run = 0;
   int   sar_cnt = 0;
   logic sar_hang = 1'b0;

   function automatic logic [5:0] sar_val(input logic [2:0] c);
      case (c)
         3'd0:    return 6'h07;
         3'd1:    return 6'h2A;
         3'd2:    return 6'h33;
         3'd3:    return 6'h15;
         default: return 6'h3F;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_mask(input logic [3:0] m);
      for (int i = 0; i < NCH; i++)
         if (m[i]) q.push_back('{ch: 3'(i), data: sar_val(3'(i))});
   endtask

   task automatic pulse_start(input logic [3:0] m);
      @(negedge clk);
      bus.ch_mask = m;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!bus.busy && q.size() == 0) break;
      end
      chk({name, "_done_in_budget"}, 32'(i < budget), 32'd1);
   endtask

   // SAR model: sar_done pulses SAR_LAT cycles after sar_ena rises, data keyed on mux_sel.
   always @(negedge clk) begin
      if (rest || !bus.sar_ena) begin
         sar_cnt      = 0;
         bus.sar_done = 1'b0;
      end else begin
         sar_cnt++;
         if (!sar_hang && sar_cnt == SAR_LAT) begin
            bus.sar_done = 1'b1;
            bus.sar_dout = sar_val(bus.mux_sel);
         end else begin
            bus.sar_done = 1'b0;
         end
      end
   end

   // Monitor: result scoreboard, sample window length, mux channel during sample.
   always @(negedge clk) begin
      if (!rest) begin
         if (bus.res_valid && bus.res_ready) begin
            nvec++;
            if (q.size() == 0) begin
               nerr++;
               $display("FAIL extra_result: got ch %0d data %0h expected no result", bus.res_ch, bus.res_data);
            end else begin
               res_t e;
               e = q.pop_front();
               npop++;
               if (bus.res_ch !== e.ch || bus.res_data !== e.data) begin
                  nerr++;
                  $display("FAIL result: got ch %0d data %0h expected ch %0d data %0h",
                           bus.res_ch, bus.res_data, e.ch, e.data);
               end
            end
         end
         if (bus.sample) begin
            sample_run++;
            if (q.size() > 0) chk("mux_sel", 32'(bus.mux_sel), 32'(q[0].ch));
         end else if (sample_run != 0) begin
            chk("sample_len", 32'(sample_run), 32'(SAMPLE_CYC));
            sample_run = 0;
         end
      end else begin
         sample_run = 0;
      end
   end

   vec_t vecs[6];

   initial begin
      int ena_cnt;
      int base;
      int i;
      logic [2:0] hold_ch;
      logic [5:0] hold_data;

      vecs[0] = '{mask: 4'b1010, nres: 2};
      vecs[1] = '{mask: 4'b0001, nres: 1};
      vecs[2] = '{mask: 4'b1111, nres: 4};
      vecs[3] = '{mask: 4'b0100, nres: 1};
      vecs[4] = '{mask: 4'b1000, nres: 1};
      vecs[5] = '{mask: 4'b0110, nres: 2};

      rest          = 1'b1;
      bus.start     = 1'b0;
      bus.cont      = 1'b0;
      bus.ch_mask   = '0;
      bus.res_ready = 1'b1;
      bus.sar_done  = 1'b0;
      bus.sar_dout  = '0;

      // Reset and ignored empty-mask start
      repeat (2) @(negedge clk);
      chk("rst_sar_rest", 32'(bus.sar_rest), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_sample", 32'(bus.sample), 32'd0);
      chk("rst_sar_ena", 32'(bus.sar_ena), 32'd0);
      rest = 1'b0;
      pulse_start(4'b0000);
      @(negedge clk);
      chk("empty_mask_busy", 32'(bus.busy), 32'd0);

      // Vector table, single scans with ready held high
      foreach (vecs[k]) begin
         base = npop;
         push_mask(vecs[k].mask);
         pulse_start(vecs[k].mask);
         chk("scan_busy", 32'(bus.busy), 32'd1);
         wait_idle("scan", 200);
         chk("scan_count", 32'(npop - base), 32'(vecs[k].nres));
      end

      // Backpressure: hold ready low for 10 cycles with a result pending
      bus.res_ready = 1'b0;
      push_mask(4'b0011);
      pulse_start(4'b0011);
      for (i = 0; i < 100 && !bus.res_valid; i++) @(negedge clk);
      chk("bp_valid_seen", 32'(bus.res_valid), 32'd1);
      hold_ch   = 3'd0;
      hold_data = sar_val(3'd0);
      repeat (10) begin
         @(negedge clk);
         chk("bp_res_ch", 32'(bus.res_ch), 32'(hold_ch));
         chk("bp_res_data", 32'(bus.res_data), 32'(hold_data));
         chk("bp_no_sample", 32'(bus.sample), 32'd0);
      end
      bus.res_ready = 1'b1;
      wait_idle("bp", 200);

      // Continuous wrap on a single channel, then drop cont
      base     = npop;
      bus.cont = 1'b1;
      push_mask(4'b0001);
      push_mask(4'b0001);
      push_mask(4'b0001);
      pulse_start(4'b0001);
      for (i = 0; i < 200 && npop < base + 2; i++) @(negedge clk);
      @(negedge clk);
      bus.cont = 1'b0;
      wait_idle("cont", 200);
      chk("cont_count", 32'(npop - base), 32'd3);

      // Timeout: SAR never answers
      sar_hang = 1'b1;
      base     = npop;
      pulse_start(4'b0100);
      ena_cnt = 0;
      for (i = 0; i < 200; i++) begin
         if (bus.sar_ena) ena_cnt++;
         if (!bus.busy) break;
         @(negedge clk);
      end
      chk("tmo_conv_cycles", 32'(ena_cnt), 32'(TMO));
      chk("tmo_err", 32'(bus.err), 32'd1);
      chk("tmo_busy", 32'(bus.busy), 32'd0);
      chk("tmo_no_result", 32'(npop - base), 32'd0);
      sar_hang = 1'b0;
      push_mask(4'b0100);
      pulse_start(4'b0100);
      chk("tmo_err_cleared", 32'(bus.err), 32'd0);
      wait_idle("tmo_recover", 200);

      // Reset during CONV discards the in-flight result
      push_mask(4'b1000);
      pulse_start(4'b1000);
      for (i = 0; i < 100 && !bus.sar_ena; i++) @(negedge clk);
      chk("mid_conv_reached", 32'(bus.sar_ena), 32'd1);
      @(negedge clk);
      rest = 1'b1;
      @(negedge clk);
      q.delete();
      chk("mid_mux_sel", 32'(bus.mux_sel), 32'd0);
      chk("mid_sample", 32'(bus.sample), 32'd0);
      chk("mid_sar_rest", 32'(bus.sar_rest), 32'd1);
      chk("mid_sar_ena", 32'(bus.sar_ena), 32'd0);
      chk("mid_res_data", 32'(bus.res_data), 32'd0);
      chk("mid_res_ch", 32'(bus.res_ch), 32'd0);
      chk("mid_res_valid", 32'(bus.res_valid), 32'd0);
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_err", 32'(bus.err), 32'd0);
      rest = 1'b0;
      repeat (15) @(negedge clk);
      chk("mid_still_idle", 32'(bus.busy), 32'd0);

      // Start pulsed during SAMPLE and mask changed after latch are ignored
      base = npop;
      push_mask(4'b0101);
      pulse_start(4'b0101);
      chk("ign_in_sample", 32'(bus.sample), 32'd1);
      bus.ch_mask = 4'b1010;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      chk("ign_mux_sel", 32'(bus.mux_sel), 32'd0);
      wait_idle("ign", 200);
      chk("ign_count", 32'(npop - base), 32'd2);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
